pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register for the pipelined core. It is the generalised successor to the fixed ID/EX latch. It carries a CTRL_W-bit control bundle and a DATA_W-bit data bundle between two pipe stages using a valid/ready handshake, and it honours an external memory stall plus a synchronous flush that inserts a bubble. An optional skid entry registers `ready_o`, which breaks the combinational ready path between stages.

---
 rtl/pipe_skid_stage.sv | 123 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with optional skid entry (SKID=1 registers ready_o).
// Carries a control and a data bundle; supports an external stall and a flush that inserts a bubble.
module pipe_skid_stage #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              xfer_in;
    logic              xfer_out;
    logic              load_main;
    logic              load_skid;
    logic              move_skid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign valid_o  = (state != EMPTY);
    assign xfer_in  = valid_i & ready_o;
    assign xfer_out = valid_o & ready_i & ~stall_i;

    // With a skid entry, ready depends on state only, cutting the ready path between stages.
    if (SKID != 0) begin : g_skid_ready
        assign ready_o = (state != FULL);
    end else begin : g_comb_ready
        assign ready_o = ~valid_o | (ready_i & ~stall_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        load_main = 1'b1;
                    end else if (xfer_in) begin
                        // Only reachable with SKID=1: with SKID=0 ready_o is low here.
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (xfer_out) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer_out) begin
                        state_nxt = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Bundle registers load only on accept or skid->main move.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                main_ctrl <= ctrl_i;
                main_data <= data_i;
            end else if (move_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= ctrl_i;
                skid_data <= data_i;
            end
        end
    end

    assign ctrl_o = valid_o ? main_ctrl : '0;
    assign data_o = main_data;
    assign occ_o  = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: SKID=1 and SKID=0 instances share stimulus; each has a queue model.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        valid_i;
    logic        ready_i;
    logic [7:0]  ctrl_i;
    logic [15:0] data_i;

    logic        valid1, ready1, valid0, ready0;
    logic [7:0]  ctrl1, ctrl0;
    logic [15:0] data1, data0;
    logic [1:0]  occ1, occ0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [23:0] q [2][$];

    typedef struct {
        logic [3:0]  vrsf;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(16), .CTRL_W(8), .SKID(1)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
        .valid_i(valid_i), .ready_o(ready1), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid1), .ready_i(ready_i), .ctrl_o(ctrl1), .data_o(data1), .occ_o(occ1)
    );

    pipe_skid_stage #(.DATA_W(16), .CTRL_W(8), .SKID(0)) u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
        .valid_i(valid_i), .ready_o(ready0), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid0), .ready_i(ready_i), .ctrl_o(ctrl0), .data_o(data0), .occ_o(occ0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic r, input logic s, input logic f,
                         input logic [15:0] d);
        valid_i = v;
        ready_i = r;
        stall   = s;
        flush   = f;
        data_i  = d;
        ctrl_i  = {1'b1, d[6:0]};
    endtask

    // Reference model step for instance m, evaluated mid-cycle on the values that the next edge sees.
    task automatic sb(input int m, input logic skid, input logic vo, input logic ro,
                      input logic [15:0] d, input logic [7:0] c, input logic [1:0] occ);
        int   n;
        logic exp_v, exp_r;
        n     = q[m].size();
        exp_v = (n > 0);
        exp_r = skid ? (n < 2) : ((n == 0) || (ready_i && !stall));
        chk($sformatf("sb%0d_valid", m), 32'(vo), 32'(exp_v));
        chk($sformatf("sb%0d_occ", m), 32'(occ), 32'(n));
        chk($sformatf("sb%0d_ready", m), 32'(ro), 32'(exp_r));
        if (exp_v) chk($sformatf("sb%0d_head", m), 32'({c, d}), 32'(q[m][0]));
        else       chk($sformatf("sb%0d_bubble_ctrl", m), 32'(c), 32'(0));
        if (exp_v && ready_i && !stall) q[m].pop_front();
        if (flush) q[m].delete();
        else if (valid_i && exp_r) q[m].push_back({ctrl_i, data_i});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q[0].delete();
            q[1].delete();
        end else begin
            sb(1, 1'b1, valid1, ready1, data1, ctrl1, occ1);
            sb(0, 1'b0, valid0, ready0, data0, ctrl0, occ0);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_valid1"}, 32'(valid1), 32'(0));
        chk({tag, "_ctrl1"},  32'(ctrl1),  32'(0));
        chk({tag, "_occ1"},   32'(occ1),   32'(0));
        chk({tag, "_ready1"}, 32'(ready1), 32'(1));
        chk({tag, "_valid0"}, 32'(valid0), 32'(0));
        chk({tag, "_ctrl0"},  32'(ctrl0),  32'(0));
        chk({tag, "_occ0"},   32'(occ0),   32'(0));
    endtask

    initial begin
        // vrsf = {valid_i, ready_i, stall, flush}; expectations are SKID=1 outputs after the edge
        tbl[0]  = '{4'b1100, 16'd1, 1'b1, 16'd1, 2'd1, 1'b1};
        tbl[1]  = '{4'b1100, 16'd2, 1'b1, 16'd2, 2'd1, 1'b1};
        tbl[2]  = '{4'b1000, 16'd3, 1'b1, 16'd2, 2'd2, 1'b0};
        tbl[3]  = '{4'b1000, 16'd4, 1'b1, 16'd2, 2'd2, 1'b0};
        tbl[4]  = '{4'b0110, 16'd0, 1'b1, 16'd2, 2'd2, 1'b0};
        tbl[5]  = '{4'b0100, 16'd0, 1'b1, 16'd3, 2'd1, 1'b1};
        tbl[6]  = '{4'b1110, 16'd5, 1'b1, 16'd3, 2'd2, 1'b0};
        tbl[7]  = '{4'b1101, 16'd6, 1'b0, 16'd0, 2'd0, 1'b1};
        tbl[8]  = '{4'b1000, 16'd7, 1'b1, 16'd7, 2'd1, 1'b1};
        tbl[9]  = '{4'b0100, 16'd0, 1'b0, 16'd0, 2'd0, 1'b1};
        tbl[10] = '{4'b1110, 16'd8, 1'b1, 16'd8, 2'd1, 1'b1};
        tbl[11] = '{4'b0110, 16'd0, 1'b1, 16'd8, 2'd1, 1'b1};
        tbl[12] = '{4'b0100, 16'd0, 1'b0, 16'd0, 2'd0, 1'b1};

        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA);
        ctrl_i = 8'hFF;
        #2;
        chk_reset("init_reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 16'(i));
            @(posedge clk); #1;
            chk($sformatf("stream%0d_data1", i), 32'(data1), 32'(i));
            chk($sformatf("stream%0d_data0", i), 32'(data0), 32'(i));
            chk($sformatf("stream%0d_occ1", i), 32'(occ1), 32'(1));
            chk($sformatf("stream%0d_valid0", i), 32'(valid0), 32'(1));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vrsf[3], tbl[i].vrsf[2], tbl[i].vrsf[1], tbl[i].vrsf[0], tbl[i].d);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), 32'(valid1), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_occ", i), 32'(occ1), 32'(tbl[i].eocc));
            chk($sformatf("tbl%0d_ready", i), 32'(ready1), 32'(tbl[i].erdy));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(data1), 32'(tbl[i].ed));
        end

        // Reset asserted mid-cycle with the skid stage full
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0022);
        @(posedge clk); #1;
        chk("pre_reset_occ1", 32'(occ1), 32'(2));
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0,
                  16'(i + 16'h100));
            @(posedge clk); #1;
        end

        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
